// File: rtl/pong_game_engine.sv
// pong_game_engine
//   Game-logic stage for the Pong VGA top level. The scan counters from the
//   sync generator drive it. Once per frame, on the tick, it updates the ball,
//   the player paddle and the rally state. It produces a registered per-pixel
//   colour.
//
// Ports
//   clk            pixel clock, shared with the sync generator
//   reset          synchronous, active-high
//   CounterX [9:0] current pixel x
//   CounterY [8:0] current line y
//   inDisplayArea  high while in the visible region
//   btn_up         paddle up (level)
//   btn_down       paddle down (level)
//   serve          starts a rally from WAIT
//   pix_R/G/B      registered pixel colour, one clk after the counters
//   hits [7:0]     paddle hits in the current rally (saturating)
//   miss           one-clk pulse when the ball leaves past the paddle
//   dbg            FSM state and game registers for observation

package pong_game_engine_pkg;
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2
    } gameState_t;

    typedef struct packed {
        gameState_t state;
        logic [9:0] ballX;
        logic [8:0] ballY;
        logic       dirRight;
        logic       dirDown;
        logic [8:0] paddleY;
        logic [5:0] missCnt;
    } engineDbg_t;
endpackage

module pong_game_engine
    import pong_game_engine_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int BALL_SPEED  = 2,
    parameter int PADDLE_X    = 16,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_STEP = 4,
    parameter int MISS_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] CounterX,
    input  logic [8:0] CounterY,
    input  logic       inDisplayArea,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       serve,
    output logic       pix_R,
    output logic       pix_G,
    output logic       pix_B,
    output logic [7:0] hits,
    output logic       miss,
    output engineDbg_t dbg
);
    // The x arithmetic is one bit wider than the x counter, and the y
    // arithmetic one bit wider than the y counter. Sums near the far walls
    // therefore never wrap.
    localparam logic [10:0] X_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] X_SPD   = 11'(BALL_SPEED);
    localparam logic [10:0] X_SIZE  = 11'(BALL_SIZE);
    localparam logic [10:0] X_PAD_L = 11'(PADDLE_X);
    localparam logic [10:0] X_PAD_R = 11'(PADDLE_X + PADDLE_W);
    localparam logic [9:0]  Y_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  Y_SPD   = 10'(BALL_SPEED);
    localparam logic [9:0]  Y_SIZE  = 10'(BALL_SIZE);
    localparam logic [9:0]  Y_PAD_H = 10'(PADDLE_H);
    localparam logic [9:0]  Y_STEP  = 10'(PADDLE_STEP);
    localparam logic [9:0]  Y_PMAX  = 10'(V_ACTIVE - PADDLE_H);

    gameState_t state, stateNext;
    logic [9:0] ballX, ballXNext;
    logic [8:0] ballY, ballYNext;
    logic       dirRight, dirRightNext;
    logic       dirDown, dirDownNext;
    logic [8:0] paddleY, paddleYNext;
    logic [5:0] missCnt, missCntNext;
    logic [7:0] hitsNext;
    logic       missNext;

    logic [10:0] xW, cx;
    logic [9:0]  yW, pW, cy;
    logic        tick, overlap, hitCond, ballPx, paddlePx, borderPx;

    assign xW = {1'b0, ballX};
    assign yW = {1'b0, ballY};
    assign pW = {1'b0, paddleY};
    assign cx = {1'b0, CounterX};
    assign cy = {1'b0, CounterY};

    // The tick lands in vertical blanking, so the picture never sees a
    // half-updated frame.
    assign tick = (CounterX == 10'd0) && (cy == Y_ACT);

    // The overlap test uses the paddle position from before this tick's move.
    assign overlap = (yW + Y_SIZE > pW) && (yW < pW + Y_PAD_H);
    assign hitCond = !dirRight && (xW >= X_PAD_R) && (xW <= X_PAD_R + X_SPD) && overlap;

    always_comb begin
        stateNext    = state;
        ballXNext    = ballX;
        ballYNext    = ballY;
        dirRightNext = dirRight;
        dirDownNext  = dirDown;
        paddleYNext  = paddleY;
        missCntNext  = missCnt;
        hitsNext     = hits;
        missNext     = 1'b0;

        if (tick) begin
            case ({btn_up, btn_down})
                2'b10:   paddleYNext = (pW < Y_STEP) ? 9'd0 : 9'(pW - Y_STEP);
                2'b01:   paddleYNext = (pW + Y_STEP > Y_PMAX) ? 9'(Y_PMAX) : 9'(pW + Y_STEP);
                default: paddleYNext = paddleY;
            endcase

            case (state)
                ST_WAIT: begin
                    if (serve) begin
                        stateNext = ST_PLAY;
                        hitsNext  = 8'd0;
                    end
                end
                ST_PLAY: begin
                    if (dirRight) begin
                        if (xW + X_SPD + X_SIZE >= X_ACT) begin
                            ballXNext    = 10'(X_ACT - X_SIZE);
                            dirRightNext = 1'b0;
                        end else begin
                            ballXNext = 10'(xW + X_SPD);
                        end
                    end else if (hitCond) begin
                        ballXNext    = 10'(X_PAD_R);
                        dirRightNext = 1'b1;
                        hitsNext     = (hits == 8'hFF) ? hits : hits + 8'd1;
                    end else if (xW < X_SPD) begin
                        stateNext = ST_MISS;
                        missNext  = 1'b1;
                        hitsNext  = 8'd0;
                    end else begin
                        ballXNext = 10'(xW - X_SPD);
                    end

                    if (dirDown) begin
                        if (yW + Y_SPD + Y_SIZE >= Y_ACT) begin
                            ballYNext   = 9'(Y_ACT - Y_SIZE);
                            dirDownNext = 1'b0;
                        end else begin
                            ballYNext = 9'(yW + Y_SPD);
                        end
                    end else if (yW < Y_SPD) begin
                        ballYNext   = 9'd0;
                        dirDownNext = 1'b1;
                    end else begin
                        ballYNext = 9'(yW - Y_SPD);
                    end
                end
                ST_MISS: begin
                    if ({1'b0, missCnt} + 7'd1 == 7'(MISS_FRAMES)) begin
                        stateNext    = ST_WAIT;
                        ballXNext    = 10'(H_ACTIVE / 2);
                        ballYNext    = 9'(V_ACTIVE / 2);
                        dirRightNext = 1'b1;
                        dirDownNext  = 1'b1;
                        missCntNext  = 6'd0;
                    end else begin
                        missCntNext = missCnt + 6'd1;
                    end
                end
                default: stateNext = ST_WAIT;
            endcase
        end
    end

    assign ballPx = (cx >= xW) && (cx < xW + X_SIZE) &&
                    (cy >= yW) && (cy < yW + Y_SIZE) && (state != ST_MISS);
    assign paddlePx = (cx >= X_PAD_L) && (cx < X_PAD_R) &&
                      (cy >= pW) && (cy < pW + Y_PAD_H);
    assign borderPx = (cx == 11'd0) || (cx == X_ACT - 11'd1) ||
                      (cy == 10'd0) || (cy == Y_ACT - 10'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_WAIT;
            ballX    <= 10'(H_ACTIVE / 2);
            ballY    <= 9'(V_ACTIVE / 2);
            dirRight <= 1'b1;
            dirDown  <= 1'b1;
            paddleY  <= 9'((V_ACTIVE - PADDLE_H) / 2);
            missCnt  <= 6'd0;
            hits     <= 8'd0;
            miss     <= 1'b0;
            pix_R    <= 1'b0;
            pix_G    <= 1'b0;
            pix_B    <= 1'b0;
        end else begin
            state    <= stateNext;
            ballX    <= ballXNext;
            ballY    <= ballYNext;
            dirRight <= dirRightNext;
            dirDown  <= dirDownNext;
            paddleY  <= paddleYNext;
            missCnt  <= missCntNext;
            hits     <= hitsNext;
            miss     <= missNext;
            pix_R    <= ballPx & inDisplayArea;
            pix_G    <= (ballPx | paddlePx) & inDisplayArea;
            pix_B    <= (ballPx | borderPx) & inDisplayArea;
        end
    end

    assign dbg = '{state: state, ballX: ballX, ballY: ballY, dirRight: dirRight,
                   dirDown: dirDown, paddleY: paddleY, missCnt: missCnt};
endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine
//   Directed bench for pong_game_engine. Frame ticks are driven explicitly
//   as CounterX=0, CounterY=480 for one clk. Pixel probes present a
//   coordinate and read the colour one clk later.

module tb_pong_game_engine;
    import pong_game_engine_pkg::*;

    // clock / reset
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] CounterX = 10'd5;
    logic [8:0] CounterY = 9'd481;
    logic       inDisplayArea = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       serve = 1'b0;
    logic       pix_R, pix_G, pix_B;
    logic [7:0] hits;
    logic       miss;
    engineDbg_t dbg;

    always #5 clk = ~clk;

    pong_game_engine dut (
        .clk(clk),
        .reset(reset),
        .CounterX(CounterX),
        .CounterY(CounterY),
        .inDisplayArea(inDisplayArea),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .serve(serve),
        .pix_R(pix_R),
        .pix_G(pix_G),
        .pix_B(pix_B),
        .hits(hits),
        .miss(miss),
        .dbg(dbg)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int missHighCycles = 0;
    int missSnap = 0;
    logic [2:0] rgb;

    always @(negedge clk) if (miss === 1'b1) missHighCycles++;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tickOnce();
        @(negedge clk);
        CounterX = 10'd0;
        CounterY = 9'd480;
        inDisplayArea = 1'b0;
        @(negedge clk);
        CounterX = 10'd5;
        CounterY = 9'd481;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) tickOnce();
    endtask

    task automatic serveTick();
        serve = 1'b1;
        tickOnce();
        serve = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input logic disp, output logic [2:0] col);
        @(negedge clk);
        CounterX = 10'(x);
        CounterY = 9'(y);
        inDisplayArea = disp;
        @(negedge clk);
        col = {pix_R, pix_G, pix_B};
        CounterX = 10'd5;
        CounterY = 9'd481;
        inDisplayArea = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkValue({tag, ".state"}, 32'(dbg.state), 32'(ST_WAIT));
        checkValue({tag, ".ballX"}, 32'(dbg.ballX), 320);
        checkValue({tag, ".ballY"}, 32'(dbg.ballY), 240);
        checkValue({tag, ".dirRight"}, 32'(dbg.dirRight), 1);
        checkValue({tag, ".dirDown"}, 32'(dbg.dirDown), 1);
        checkValue({tag, ".paddleY"}, 32'(dbg.paddleY), 208);
        checkValue({tag, ".missCnt"}, 32'(dbg.missCnt), 0);
        checkValue({tag, ".hits"}, 32'(hits), 0);
        checkValue({tag, ".miss"}, 32'(miss), 0);
        checkValue({tag, ".pix"}, 32'({pix_R, pix_G, pix_B}), 0);
    endtask

    initial begin
        // reset state and idle WAIT
        applyReset();
        checkResetState("rst");
        tickN(3);
        checkValue("wait3.ballX", 32'(dbg.ballX), 320);
        checkValue("wait3.ballY", 32'(dbg.ballY), 240);
        checkValue("wait3.paddleY", 32'(dbg.paddleY), 208);
        checkValue("wait3.state", 32'(dbg.state), 32'(ST_WAIT));
        probe(320, 240, 1'b1, rgb);
        checkValue("pix.ball", 32'(rgb), 3'b111);
        probe(20, 250, 1'b1, rgb);
        checkValue("pix.paddle", 32'(rgb), 3'b010);
        probe(0, 100, 1'b1, rgb);
        checkValue("pix.border", 32'(rgb), 3'b001);
        probe(320, 240, 1'b0, rgb);
        checkValue("pix.blank", 32'(rgb), 3'b000);
        probe(400, 300, 1'b1, rgb);
        checkValue("pix.empty", 32'(rgb), 3'b000);

        // serve and walls
        serveTick();
        checkValue("serve.state", 32'(dbg.state), 32'(ST_PLAY));
        checkValue("serve.ballX", 32'(dbg.ballX), 320);
        tickN(10);
        checkValue("t10.ballX", 32'(dbg.ballX), 340);
        checkValue("t10.ballY", 32'(dbg.ballY), 260);
        tickN(106);
        checkValue("t116.ballY", 32'(dbg.ballY), 472);
        checkValue("t116.dirDown", 32'(dbg.dirDown), 0);
        checkValue("t116.ballX", 32'(dbg.ballX), 552);
        tickN(40);
        checkValue("t156.ballX", 32'(dbg.ballX), 632);
        checkValue("t156.dirRight", 32'(dbg.dirRight), 0);
        checkValue("t156.ballY", 32'(dbg.ballY), 392);

        // return via top wall, paddle hit at default paddle position
        tickN(303);
        checkValue("t459.ballX", 32'(dbg.ballX), 26);
        checkValue("t459.ballY", 32'(dbg.ballY), 212);
        checkValue("t459.hits", 32'(hits), 0);
        tickOnce();
        checkValue("hit.ballX", 32'(dbg.ballX), 24);
        checkValue("hit.dirRight", 32'(dbg.dirRight), 1);
        checkValue("hit.hits", 32'(hits), 1);
        checkValue("hit.ballY", 32'(dbg.ballY), 214);
        tickOnce();
        checkValue("t461.ballX", 32'(dbg.ballX), 26);

        // reset mid-PLAY
        applyReset();
        checkResetState("rstPlay");

        // paddle movement and saturation
        btn_up = 1'b1;
        btn_down = 1'b1;
        tickN(3);
        checkValue("both.paddleY", 32'(dbg.paddleY), 208);
        btn_down = 1'b0;
        tickN(51);
        checkValue("up51.paddleY", 32'(dbg.paddleY), 4);
        tickOnce();
        checkValue("up52.paddleY", 32'(dbg.paddleY), 0);
        tickN(8);
        checkValue("up60.paddleY", 32'(dbg.paddleY), 0);
        btn_up = 1'b0;

        // miss with the paddle parked at the top
        missSnap = missHighCycles;
        serveTick();
        tickN(472);
        checkValue("t472.ballX", 32'(dbg.ballX), 0);
        checkValue("t472.ballY", 32'(dbg.ballY), 238);
        checkValue("t472.miss", 32'(miss), 0);
        tickOnce();
        checkValue("miss.pulse", 32'(miss), 1);
        checkValue("miss.state", 32'(dbg.state), 32'(ST_MISS));
        checkValue("miss.hits", 32'(hits), 0);
        checkValue("miss.ballY", 32'(dbg.ballY), 240);
        @(negedge clk);
        checkValue("miss.pulseEnd", 32'(miss), 0);
        probe(2, 242, 1'b1, rgb);
        checkValue("miss.hidden", 32'(rgb), 3'b000);
        tickN(59);
        checkValue("miss59.state", 32'(dbg.state), 32'(ST_MISS));
        checkValue("miss59.missCnt", 32'(dbg.missCnt), 59);
        tickOnce();
        checkValue("miss60.state", 32'(dbg.state), 32'(ST_WAIT));
        checkValue("miss60.ballX", 32'(dbg.ballX), 320);
        checkValue("miss60.ballY", 32'(dbg.ballY), 240);
        checkValue("miss60.dirRight", 32'(dbg.dirRight), 1);
        checkValue("miss60.dirDown", 32'(dbg.dirDown), 1);
        checkValue("miss60.missCnt", 32'(dbg.missCnt), 0);
        checkValue("miss.pulseCount", 32'(missHighCycles - missSnap), 1);
        probe(323, 243, 1'b1, rgb);
        checkValue("miss60.pix", 32'(rgb), 3'b111);

        // reset mid-MISS, then a normal serve
        serveTick();
        tickN(473);
        checkValue("miss2.state", 32'(dbg.state), 32'(ST_MISS));
        tickN(10);
        checkValue("miss2.missCnt", 32'(dbg.missCnt), 10);
        applyReset();
        checkResetState("rstMiss");
        serveTick();
        tickN(10);
        checkValue("reserve.state", 32'(dbg.state), 32'(ST_PLAY));
        checkValue("reserve.ballX", 32'(dbg.ballX), 340);
        checkValue("reserve.ballY", 32'(dbg.ballY), 260);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
